// File: rtl/ps2_mouse_packet_ctrl.sv
// ps2_mouse_packet_ctrl: frames 3/4-byte PS/2 mouse packets, saturates deltas to 8 bits, toggles ms_upd per packet.
// Latency: outputs and the ms_upd toggle update on the edge that accepts the final byte; sync_err is registered on the event edge.
// Backpressure: none; a byte is taken on every rx_valid cycle, back-to-back included.
module ps2_mouse_packet_ctrl #(
  parameter int TIMEOUT = 56000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       wheel_mode,
  output logic [7:0] ms_x,
  output logic [7:0] ms_y,
  output logic [3:0] ms_z,
  output logic [2:0] ms_b,
  output logic       ms_upd,
  output logic       sync_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {B0, B1, B2, B3} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Byte 0 minus the sync bit: {y_ovf, x_ovf, y_sign, x_sign, btn[2:0]}
  logic [6:0]    hdr_q, hdr_d;
  logic [7:0]    xb_q, xb_d;
  logic [7:0]    yb_q, yb_d;
  logic          mode_q, mode_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    y_q, y_d;
  logic [3:0]    z_q, z_d;
  logic [2:0]    b_q, b_d;
  logic          upd_q, upd_d;
  logic          err_q, err_d;

  logic          timeout;
  logic          done;
  logic [7:0]    ybyte;
  logic [3:0]    zval;

  // Saturate a 9-bit sign/magnitude-byte pair (plus overflow flag) into signed 8 bits.
  function automatic logic [7:0] sat9(input logic ovf, input logic sgn, input logic [7:0] mag);
    logic [7:0] r;
    if (ovf)
      r = sgn ? 8'h80 : 8'h7F;
    else if (!sgn && mag[7])
      r = 8'h7F;        // +128..+255
    else if (sgn && !mag[7])
      r = 8'h80;        // -256..-129
    else
      r = mag;
    return r;
  endfunction

  // Next-state: packet framing, timeout drop (which takes priority and re-opens byte-0 search), completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hdr_d   = hdr_q;
    xb_d    = xb_q;
    yb_d    = yb_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    b_d     = b_q;
    upd_d   = upd_q;
    err_d   = 1'b0;
    done    = 1'b0;
    ybyte   = yb_q;
    zval    = 4'h0;

    timeout = (state_q != B0) && (cnt_q == CW'(TIMEOUT));

    if (timeout) begin
      err_d   = 1'b1;
      state_d = B0;
    end

    if (state_q == B0 || timeout) begin
      // A byte arriving on the expiry cycle is judged as a fresh byte 0.
      cnt_d = '0;
      if (rx_valid) begin
        if (rx_data[3]) begin
          hdr_d   = {rx_data[7:4], rx_data[2:0]};
          mode_d  = wheel_mode;
          state_d = B1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (rx_valid) begin
      cnt_d = '0;
      case (state_q)
        B1: begin
          xb_d    = rx_data;
          state_d = B2;
        end
        B2: begin
          yb_d = rx_data;
          if (mode_q) begin
            state_d = B3;
          end else begin
            ybyte   = rx_data;
            done    = 1'b1;
            state_d = B0;
          end
        end
        default: begin
          ybyte   = yb_q;
          zval    = rx_data[3:0];
          done    = 1'b1;
          state_d = B0;
        end
      endcase
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    if (done) begin
      x_d   = sat9(hdr_q[5], hdr_q[3], xb_q);
      y_d   = sat9(hdr_q[6], hdr_q[4], ybyte);
      z_d   = zval;
      b_d   = hdr_q[2:0];
      upd_d = ~upd_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= B0;
      cnt_q   <= '0;
      hdr_q   <= '0;
      xb_q    <= '0;
      yb_q    <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      b_q     <= '0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hdr_q   <= hdr_d;
      xb_q    <= xb_d;
      yb_q    <= yb_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      b_q     <= b_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
    end
  end

  assign ms_x     = x_q;
  assign ms_y     = y_q;
  assign ms_z     = z_q;
  assign ms_b     = b_q;
  assign ms_upd   = upd_q;
  assign sync_err = err_q;

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// Scoreboard bench for ps2_mouse_packet_ctrl: packet-buffer reference model feeds expected packets and sync errors
// into queues; a negedge monitor pops them whenever ms_upd toggles or sync_err rises.
// Directed cases first, then randomized bytes, gaps and wheel_mode.
module tb_ps2_mouse_packet_ctrl;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       wheel_mode;
  logic [7:0] ms_x;
  logic [7:0] ms_y;
  logic [3:0] ms_z;
  logic [2:0] ms_b;
  logic       ms_upd;
  logic       sync_err;

  ps2_mouse_packet_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .wheel_mode(wheel_mode),
    .ms_x(ms_x), .ms_y(ms_y), .ms_z(ms_z), .ms_b(ms_b), .ms_upd(ms_upd), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic [3:0] z;
    logic [2:0] b;
    logic       upd;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];

  // Reference model: the partial packet is just a list of received bytes.
  logic [7:0] pk[$];
  logic       m_mode = 1'b0;
  int         idle = 0;
  logic       m_upd = 1'b0;

  function automatic logic [7:0] sat(input logic ovf, input logic sgn, input logic [7:0] mag);
    int v;
    logic [7:0] r;
    v = sgn ? int'(mag) - 256 : int'(mag);
    if (ovf) v = sgn ? -128 : 127;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    r = v[7:0];
    return r;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] d, input logic wm);
    logic tmo;
    logic [7:0] b0;
    exp_t e;
    tmo = 1'b0;
    if (pk.size() != 0 && idle == TO) begin
      err_q.push_back(cyc + 1);
      pk.delete();
      tmo = 1'b1;
    end
    if (pk.size() == 0) begin
      idle = 0;
      if (v) begin
        if (d[3]) begin
          pk.push_back(d);
          m_mode = wm;
        end else if (!tmo) begin
          err_q.push_back(cyc + 1);
        end
      end
    end else if (v) begin
      pk.push_back(d);
      idle = 0;
      if (pk.size() == (m_mode ? 4 : 3)) begin
        b0 = pk[0];
        e.x = sat(b0[6], b0[4], pk[1]);
        e.y = sat(b0[7], b0[5], pk[2]);
        e.z = m_mode ? pk[3][3:0] : 4'h0;
        e.b = b0[2:0];
        m_upd = ~m_upd;
        e.upd = m_upd;
        e.c = cyc + 1;
        exp_q.push_back(e);
        pk.delete();
      end
    end else begin
      idle++;
    end
  endfunction

  task automatic drive(input logic v, input logic [7:0] d, input logic wm);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data = d;
    wheel_mode = wm;
    model_step(v, d, wm);
  endtask

  task automatic pkt3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    drive(1'b1, a, 1'b0);
    drive(1'b1, b, 1'b0);
    drive(1'b1, c, 1'b0);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0);
  endtask

  int rst_cyc = -1;

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    rx_valid = 1'b0;
    rst_cyc = cyc + 1;
    pk.delete();
    idle = 0;
    m_upd = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: pops the scoreboard whenever the DUT announces a packet or a sync error.
  logic mon_en = 1'b0;
  logic prev_upd = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (mon_en) begin
      if (cyc == rst_cyc) begin
        chk("midrst_x", ms_x, 0);
        chk("midrst_y", ms_y, 0);
        chk("midrst_z", ms_z, 0);
        chk("midrst_b", ms_b, 0);
        chk("midrst_upd", ms_upd, 0);
        chk("midrst_err", sync_err, 0);
        prev_upd = 1'b0;
      end else begin
        if (ms_upd !== prev_upd) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL pkt_unexpected cycle=%0d actual=toggle required=none", cyc);
          end else begin
            me = exp_q.pop_front();
            chk("pkt_cycle", cyc, me.c);
            chk("pkt_x", ms_x, me.x);
            chk("pkt_y", ms_y, me.y);
            chk("pkt_z", ms_z, me.z);
            chk("pkt_b", ms_b, me.b);
            chk("pkt_upd", ms_upd, me.upd);
          end
        end
        prev_upd = ms_upd;
        if (sync_err !== 1'b0) begin
          if (err_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL err_unexpected cycle=%0d actual=%b required=0", cyc, sync_err);
          end else begin
            chk("err_cycle", cyc, err_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    wheel_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", ms_x, 0);
    chk("rst_y", ms_y, 0);
    chk("rst_z", ms_z, 0);
    chk("rst_b", ms_b, 0);
    chk("rst_upd", ms_upd, 0);
    chk("rst_err", sync_err, 0);
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic 3-byte, sign/overflow cases.
    pkt3(8'h08, 8'h05, 8'hFB);
    pkt3(8'h19, 8'h80, 8'h00);
    pkt3(8'h48, 8'h10, 8'h00);
    pkt3(8'h98, 8'h00, 8'h00);
    pkt3(8'h38, 8'h7F, 8'h01);
    idle_n(2);

    // 4-byte mode; wheel_mode dropping mid-packet must not shorten the packet.
    drive(1'b1, 8'h0C, 1'b1);
    drive(1'b1, 8'h01, 1'b1);
    drive(1'b1, 8'h02, 1'b0);
    drive(1'b1, 8'h0F, 1'b0);
    drive(1'b1, 8'h0A, 1'b0);
    drive(1'b1, 8'h03, 1'b1);
    drive(1'b1, 8'h04, 1'b1);

    // Desync then recovery.
    drive(1'b1, 8'h00, 1'b0);
    pkt3(8'h08, 8'h01, 8'h02);

    // Timeout drop, then a fresh packet.
    drive(1'b1, 8'h08, 1'b0);
    drive(1'b1, 8'h05, 1'b0);
    idle_n(TO + 3);
    pkt3(8'h08, 8'h01, 8'h01);

    // Byte coinciding with expiry is a byte-0 candidate (good, then bad).
    drive(1'b1, 8'h08, 1'b0);
    drive(1'b1, 8'h05, 1'b0);
    idle_n(TO);
    pkt3(8'h09, 8'h06, 8'h07);
    drive(1'b1, 8'h08, 1'b0);
    idle_n(TO);
    drive(1'b1, 8'h00, 1'b0);
    idle_n(1);
    // One cycle short of expiry: byte continues the packet.
    drive(1'b1, 8'h08, 1'b0);
    idle_n(TO - 1);
    drive(1'b1, 8'h11, 1'b0);
    drive(1'b1, 8'h22, 1'b0);
    idle_n(2);

    // Reset mid-packet.
    drive(1'b1, 8'h08, 1'b0);
    drive(1'b1, 8'h05, 1'b0);
    do_reset();
    pkt3(8'h08, 8'h03, 8'h04);
    idle_n(2);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0)
        idle_n($urandom_range(TO - 2, TO + 2));
      else
        drive(($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom));
    end

    idle_n(TO + 5);
    chk("pkt_q_empty", exp_q.size(), 0);
    chk("err_q_empty", err_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
